// File: rtl/ram_delta_pkg.sv
// Shared types and sizing helpers for the delta/PSUM SRAM sequencer and arbiter.
package ram_delta_pkg;

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int SRAM_DEPTH_BIT = 6;
  localparam int SRAM_DEPTH     = 2 ** SRAM_DEPTH_BIT;
  localparam int MAX_WR_BURST   = 4;
  localparam int BURST_CNT_W    = $clog2(MAX_WR_BURST + 1);

  // Counter width able to hold 0..max_burst inclusive.
  function automatic int burst_cnt_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/ram_delta_rd_pipe.sv
// Read-valid delay line: tracks granted reads through the macro's read latency.
module ram_delta_rd_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vld_in,
  output logic vld_out
);

  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] vld_d;

  always_comb begin
    vld_d    = vld_q;
    vld_d[0] = vld_in;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  assign vld_out = vld_q[RD_LAT-1];

endmodule

// File: rtl/ram_delta_arb.sv
// Single-port delta/PSUM SRAM front end: write/read arbitration with a bounded
// write burst, plus a full-array clear sweep run before each layer.
module ram_delta_arb
  import ram_delta_pkg::*;
#(
  parameter int SRAM_DEPTH_BIT = 6,
  parameter int SRAM_WIDTH     = 128,
  parameter int RD_LAT         = 1,
  parameter int MAX_WR_BURST   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr_start,
  output logic                      clr_busy,
  output logic                      clr_done,
  input  logic                      wr_req,
  input  logic [SRAM_DEPTH_BIT-1:0] wr_addr,
  input  logic [SRAM_WIDTH-1:0]     wr_data,
  output logic                      wr_gnt,
  input  logic                      rd_req,
  input  logic [SRAM_DEPTH_BIT-1:0] rd_addr,
  output logic                      rd_gnt,
  output logic                      rd_valid,
  output logic [SRAM_WIDTH-1:0]     rd_data,
  output logic                      ram_read_en,
  output logic                      ram_write_en,
  output logic [SRAM_DEPTH_BIT-1:0] ram_addr_r,
  output logic [SRAM_DEPTH_BIT-1:0] ram_addr_w,
  output logic [SRAM_WIDTH-1:0]     ram_data_in,
  input  logic [SRAM_WIDTH-1:0]     ram_data_out
);

  localparam int                        BW        = burst_cnt_w(MAX_WR_BURST);
  localparam logic [BW-1:0]             BURST_MAX = BW'(MAX_WR_BURST);
  localparam logic [SRAM_DEPTH_BIT-1:0] LAST_ADDR = '1;

  state_e                    state_q, state_d;
  logic [BW-1:0]             wr_burst_cnt_q, wr_burst_cnt_d;
  logic [SRAM_DEPTH_BIT-1:0] clr_addr_q, clr_addr_d;
  logic                      wr_gnt_c, rd_gnt_c, clr_wr_c;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    wr_gnt_c   = 1'b0;
    rd_gnt_c   = 1'b0;
    clr_wr_c   = 1'b0;
    case (state_q)
      ST_ARB: begin
        // The clear-start cycle grants nothing; held requests wait out the sweep.
        if (clr_start) begin
          state_d = ST_CLEAR;
        end else if (wr_req && !(rd_req && (wr_burst_cnt_q == BURST_MAX))) begin
          wr_gnt_c = 1'b1;
        end else if (rd_req) begin
          rd_gnt_c = 1'b1;
        end
      end
      ST_CLEAR: begin
        clr_wr_c   = 1'b1;
        clr_addr_d = clr_addr_q + SRAM_DEPTH_BIT'(1);
        if (clr_addr_q == LAST_ADDR) begin
          state_d    = ST_DONE;
          clr_addr_d = '0;
        end
      end
      ST_DONE: state_d = ST_ARB;
      default: state_d = ST_ARB;
    endcase
  end

  // Burst count only advances while a read is actually waiting.
  always_comb begin
    wr_burst_cnt_d = wr_burst_cnt_q;
    if (!rd_req || rd_gnt_c) begin
      wr_burst_cnt_d = '0;
    end else if (wr_gnt_c && (wr_burst_cnt_q != BURST_MAX)) begin
      wr_burst_cnt_d = wr_burst_cnt_q + BW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_ARB;
      wr_burst_cnt_q <= '0;
      clr_addr_q     <= '0;
    end else begin
      state_q        <= state_d;
      wr_burst_cnt_q <= wr_burst_cnt_d;
      clr_addr_q     <= clr_addr_d;
    end
  end

  // Grants are combinational from requests, so gate them with reset directly.
  assign wr_gnt       = wr_gnt_c & rst_n;
  assign rd_gnt       = rd_gnt_c & rst_n;
  assign ram_write_en = (wr_gnt_c | clr_wr_c) & rst_n;
  assign ram_read_en  = rd_gnt;
  assign ram_addr_w   = clr_wr_c ? clr_addr_q : wr_addr;
  assign ram_data_in  = clr_wr_c ? '0 : wr_data;
  assign ram_addr_r   = rd_addr;
  assign clr_busy     = (state_q == ST_CLEAR);
  assign clr_done     = (state_q == ST_DONE);
  assign rd_data      = ram_data_out;

  ram_delta_rd_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .vld_in  (rd_gnt),
    .vld_out (rd_valid)
  );

endmodule

// File: tb/tb_ram_delta_arb.sv
// Scoreboard bench for ram_delta_arb: RD_LAT=1 instance for arbitration/clear,
// RD_LAT=2 instance for the longer read pipeline.
module tb_ram_delta_arb;
  import ram_delta_pkg::*;

  localparam int AW = 6;
  localparam int DW = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t q1[$];
  exp_t q2[$];

  // DUT 1 (RD_LAT = 1)
  logic          clr_start, clr_busy, clr_done;
  logic          wr_req, wr_gnt, rd_req, rd_gnt, rd_valid;
  logic [AW-1:0] wr_addr, rd_addr, ram_addr_r, ram_addr_w;
  logic [DW-1:0] wr_data, rd_data, ram_data_in, ram_data_out;
  logic          ram_read_en, ram_write_en;

  // DUT 2 (RD_LAT = 2)
  logic          b_clr_start, b_clr_busy, b_clr_done;
  logic          b_wr_req, b_wr_gnt, b_rd_req, b_rd_gnt, b_rd_valid;
  logic [AW-1:0] b_wr_addr, b_rd_addr, b_ram_addr_r, b_ram_addr_w;
  logic [DW-1:0] b_wr_data, b_rd_data, b_ram_data_in, b_ram_data_out;
  logic          b_ram_read_en, b_ram_write_en;

  ram_delta_arb #(.SRAM_DEPTH_BIT(AW), .SRAM_WIDTH(DW), .RD_LAT(1), .MAX_WR_BURST(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .ram_read_en(ram_read_en), .ram_write_en(ram_write_en), .ram_addr_r(ram_addr_r),
    .ram_addr_w(ram_addr_w), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  ram_delta_arb #(.SRAM_DEPTH_BIT(AW), .SRAM_WIDTH(DW), .RD_LAT(2), .MAX_WR_BURST(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .clr_start(b_clr_start), .clr_busy(b_clr_busy), .clr_done(b_clr_done),
    .wr_req(b_wr_req), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_gnt(b_wr_gnt),
    .rd_req(b_rd_req), .rd_addr(b_rd_addr), .rd_gnt(b_rd_gnt), .rd_valid(b_rd_valid), .rd_data(b_rd_data),
    .ram_read_en(b_ram_read_en), .ram_write_en(b_ram_write_en), .ram_addr_r(b_ram_addr_r),
    .ram_addr_w(b_ram_addr_w), .ram_data_in(b_ram_data_in), .ram_data_out(b_ram_data_out)
  );

  // SRAM macro models: 1-cycle and 2-cycle read latency.
  logic [DW-1:0] mem1 [SRAM_DEPTH];
  logic [DW-1:0] mem2 [SRAM_DEPTH];
  logic [DW-1:0] p1, bp1, bp2;
  always @(posedge clk) begin
    if (ram_write_en) mem1[ram_addr_w] <= ram_data_in;
    if (ram_read_en)  p1 <= mem1[ram_addr_r];
    if (b_ram_write_en) mem2[b_ram_addr_w] <= b_ram_data_in;
    if (b_ram_read_en)  bp1 <= mem2[b_ram_addr_r];
    bp2 <= bp1;
  end
  assign ram_data_out   = p1;
  assign b_ram_data_out = bp2;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Read-return monitors: pop the expected word and its due cycle.
  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst_n && rd_valid) begin
      if (q1.size() == 0) chk("rd1_unexpected_valid", 1, 0);
      else begin
        e = q1.pop_front();
        chk("rd1_data", rd_data, e.data);
        chk("rd1_cycle", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (rst_n && b_rd_valid) begin
      if (q2.size() == 0) chk("rd2_unexpected_valid", 1, 0);
      else begin
        e = q2.pop_front();
        chk("rd2_data", b_rd_data, e.data);
        chk("rd2_cycle", cyc, e.due);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    chk("wr_gnt", wr_gnt, 1);
    chk("wr_ram_we", {ram_write_en, ram_read_en}, 2'b10);
    chk("wr_ram_addr", ram_addr_w, a);
    chk("wr_ram_data", ram_data_in, d);
    step();
    wr_req = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    rd_req = 1'b1; rd_addr = a;
    @(negedge clk);
    chk("rd_gnt", {rd_gnt, ram_read_en, ram_write_en}, 3'b110);
    chk("rd_ram_addr", ram_addr_r, a);
    e.data = d; e.due = cyc + 1;
    q1.push_back(e);
    step();
    rd_req = 1'b0;
  endtask

  initial begin : stim
    bit [9:0] pat;
    bit       done_seen;
    exp_t     e;
    rst_n = 1'b0;
    clr_start = 0; wr_req = 1; rd_req = 1; wr_addr = 0; rd_addr = 0; wr_data = '0;
    b_clr_start = 0; b_wr_req = 0; b_rd_req = 0; b_wr_addr = 0; b_rd_addr = 0; b_wr_data = '0;

    // Reset: no grants or enables even with requests asserted.
    @(negedge clk);
    chk("reset_grants", {wr_gnt, rd_gnt, ram_write_en, ram_read_en}, 4'b0000);
    chk("reset_status", {clr_busy, clr_done, rd_valid}, 3'b000);
    wr_req = 0; rd_req = 0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outputs", {wr_gnt, rd_gnt, ram_write_en, ram_read_en, clr_busy, clr_done, rd_valid}, 7'b0);
    step();

    // Basic write, read-after-write, and a marker at the top address.
    do_write(6'd5, 128'hAB);
    do_read(6'd5, 128'hAB);
    do_write(6'd63, 128'h63);
    do_read(6'd63, 128'h63);
    do_read(6'd5, 128'hAB);

    // Both requesters held: W,W,W,W,R repeating.
    pat = 10'b0111101111;
    wr_req = 1; wr_addr = 6'd7; wr_data = 128'h77;
    rd_req = 1; rd_addr = 6'd5;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("burst_wr_gnt", wr_gnt, pat[i]);
      chk("burst_rd_gnt", rd_gnt, !pat[i]);
      if (!pat[i]) begin
        e.data = 128'hAB; e.due = cyc + 1;
        q1.push_back(e);
      end
      step();
    end
    wr_req = 0; rd_req = 0;
    do_read(6'd7, 128'h77);

    // Clear sweep with a write held across it; a second clr_start mid-sweep is ignored.
    wr_req = 1; wr_addr = 6'd9; wr_data = 128'h99;
    clr_start = 1;
    @(negedge clk);
    chk("clr_start_no_grant", {wr_gnt, ram_write_en, clr_busy}, 3'b000);
    step();
    clr_start = 0;
    for (int i = 0; i < SRAM_DEPTH; i++) begin
      @(negedge clk);
      chk("sweep_ctrl", {clr_busy, ram_write_en, wr_gnt, rd_gnt, clr_done, ram_addr_w}, {5'b11000, AW'(i)});
      chk("sweep_data", ram_data_in, 0);
      step();
      clr_start = (i == 9);
    end
    @(negedge clk);
    chk("sweep_done_pulse", {clr_done, clr_busy}, 2'b10);
    step();
    @(negedge clk);
    chk("post_sweep_done_low", clr_done, 0);
    chk("held_write_granted", {wr_gnt, ram_addr_w}, {1'b1, 6'd9});
    step();
    wr_req = 0;
    do_read(6'd5, 0);
    do_read(6'd63, 0);
    do_read(6'd7, 0);
    do_read(6'd9, 128'h99);

    // Reset in the middle of a sweep aborts it without a done pulse.
    do_write(6'd40, 128'h40);
    clr_start = 1;
    step();
    clr_start = 0;
    for (int i = 0; i < 20; i++) step();
    @(negedge clk);
    chk("abort_sweep_addr", ram_addr_w, 20);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_status", {clr_busy, clr_done, ram_write_en}, 3'b000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", {clr_busy, clr_done}, 2'b00);
      step();
    end
    do_read(6'd40, 128'h40);

    // Restart sweeps from address 0 and finishes.
    clr_start = 1;
    step();
    clr_start = 0;
    @(negedge clk);
    chk("restart_addr0", {clr_busy, ram_addr_w}, {1'b1, 6'd0});
    done_seen = 0;
    for (int k = 0; k < 100 && !done_seen; k++) begin
      step();
      @(negedge clk);
      done_seen = clr_done;
    end
    chk("restart_done_seen", done_seen, 1);
    step();
    do_read(6'd40, 0);

    // RD_LAT = 2: back-to-back reads return back-to-back two cycles later.
    b_wr_req = 1; b_wr_addr = 6'd1; b_wr_data = 128'h11;
    @(negedge clk); chk("b_wr1_gnt", b_wr_gnt, 1); step();
    b_wr_addr = 6'd2; b_wr_data = 128'h22;
    @(negedge clk); chk("b_wr2_gnt", b_wr_gnt, 1); step();
    b_wr_req = 0;
    b_rd_req = 1; b_rd_addr = 6'd1;
    @(negedge clk); chk("b_rd1_gnt", b_rd_gnt, 1);
    e.data = 128'h11; e.due = cyc + 2; q2.push_back(e);
    step();
    b_rd_addr = 6'd2;
    @(negedge clk); chk("b_rd2_gnt", b_rd_gnt, 1);
    e.data = 128'h22; e.due = cyc + 2; q2.push_back(e);
    step();
    b_rd_req = 0;
    @(negedge clk);
    chk("b_idle_status", {b_clr_busy, b_clr_done}, 2'b00);

    for (int i = 0; i < 5; i++) step();
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/ram_delta_arb.md
Name: ram_delta_arb

Overview:
- Sequencer and arbiter for one single-port delta/PSUM SRAM macro wrapper (1R-or-1W per cycle, write-dominant address mux, 1-cycle read latency).
- Shares the macro between one write requester (PE partial-sum writeback) and one read requester (output/readout path). Provides a bulk-clear sweep that zeroes the array before each layer.
- Sits directly in front of the SRAM wrapper inside the GB_PSUM group.

Parameters:
- SRAM_DEPTH_BIT, 6, address width; depth = 2**SRAM_DEPTH_BIT.
- SRAM_WIDTH, 128, data width.
- RD_LAT, 1, macro read latency in cycles (legal: 1 or 2).
- MAX_WR_BURST, 4, consecutive write grants allowed while rd_req is pending before one read is forced.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- clr_start  in  1  pulse: start clear sweep
- clr_busy  out  1  clear sweep in progress
- clr_done  out  1  1-cycle pulse after last clear write
- wr_req  in  1  write request
- wr_addr  in  SRAM_DEPTH_BIT  write address
- wr_data  in  SRAM_WIDTH  write data
- wr_gnt  out  1  write accepted this cycle (comb)
- rd_req  in  1  read request
- rd_addr  in  SRAM_DEPTH_BIT  read address
- rd_gnt  out  1  read accepted this cycle (comb)
- rd_valid  out  1  rd_data valid
- rd_data  out  SRAM_WIDTH  read data (pass-through of ram_data_out)
- ram_read_en  out  1  to wrapper read_en
- ram_write_en  out  1  to wrapper write_en
- ram_addr_r  out  SRAM_DEPTH_BIT  to wrapper addr_r
- ram_addr_w  out  SRAM_DEPTH_BIT  to wrapper addr_w
- ram_data_in  out  SRAM_WIDTH  to wrapper data_in
- ram_data_out  in  SRAM_WIDTH  from wrapper data_out

Behaviour:
- Clock and reset: clock is clk; reset is rst_n, asynchronous, active-low.
- Reset state: FSM=IDLE, wr_burst_cnt=0, clr_addr=0, rd_valid pipe=0, clr_busy=0, clr_done=0. All grants and ram enables are 0 while rst_n=0.
- FSM states:
  - IDLE/ARB (same state, named ARB): normal arbitration.
  - CLEAR: sweep.
  - DONE: 1 cycle, clr_done=1, then ARB.
- ARB → CLEAR on clr_start; the start cycle issues no grants. clr_start is ignored while in CLEAR or DONE.
- CLEAR:
  - Each cycle: ram_write_en=1, ram_addr_w=clr_addr, ram_data_in=0, clr_addr++.
  - clr_busy=1. wr_gnt=rd_gnt=0 (requesters stall, requests held).
  - When clr_addr == SRAM_DEPTH-1 is written, go to DONE and reset clr_addr to 0. The sweep takes exactly SRAM_DEPTH cycles.
- ARB grant rules (at most one grant per cycle):
  - Only wr_req → wr_gnt. Only rd_req → rd_gnt.
  - Both requests: wr_gnt unless wr_burst_cnt == MAX_WR_BURST, then rd_gnt.
  - wr_burst_cnt increments on each wr_gnt while rd_req=1.
  - wr_burst_cnt clears on rd_gnt, or on any cycle with rd_req=0. It saturates at MAX_WR_BURST.
- RAM drive:
  - ram_write_en=wr_gnt, ram_read_en=rd_gnt.
  - ram_addr_w=wr_addr, ram_addr_r=rd_addr, ram_data_in=wr_data.
  - Enables are never both 1.
- Read return:
  - rd_valid = rd_gnt delayed RD_LAT cycles (shift register, reset 0). rd_data = ram_data_out.
  - Back-to-back reads yield back-to-back rd_valid.
- Hazards:
  - Read of an address written in an earlier cycle returns new data.
  - Same-cycle read and write to the same address cannot occur, because only one is granted.
- Reset mid-sweep: async abort to ARB. The partially cleared array is not reported done.
- Handshake: a requester holds req, addr and data until it sees gnt. Dropping req without a gnt is allowed.
- Read pipeline during CLEAR entry: reads granted before CLEAR still deliver rd_valid.

Decomposition:
- Package ram_delta_pkg: FSM state enum (ST_ARB, ST_CLEAR, ST_DONE), localparam SRAM_DEPTH = 2**SRAM_DEPTH_BIT, and the burst counter width clog2(MAX_WR_BURST+1).
- One natural sub-module: ram_delta_rd_pipe (RD_LAT-deep valid shift register with async reset).
- Arbitration and FSM stay in the top module.

Test Plan:
- Reset then idle: all outputs 0. wr_req=1, addr=5, data=0xAB → wr_gnt=1, ram_write_en=1, ram_addr_w=5 same cycle.
- Read after write at addr 5 → rd_gnt, then rd_valid=1 one cycle later with rd_data=0xAB.
- wr_req and rd_req held high continuously with MAX_WR_BURST=4 → grant pattern W,W,W,W,R repeating; never two grants in one cycle.
- clr_start with depth 64 → clr_busy=1 for 64 cycles, addresses 0..63 written with 0, clr_done pulse once, then reads of any address return 0. Requests held during the sweep are granted afterwards.
- rst_n dropped at sweep address 20 → immediate return to ARB, clr_busy=0, no clr_done. A new clr_start restarts from address 0.
- RD_LAT=2 build: reads at cycles t and t+1 → rd_valid at t+2 and t+3 with the matching data.
